imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle RV32I core reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction-memory write port and validates a trailing XOR checksum.
- Holds the core in reset (cpu_hold) until a complete, valid image has been written.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words (64).
TIMEOUT, 100000, maximum idle cycles between accepted bytes once a frame has started.
SYNC, 8'hA5, frame start byte.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
s_data  input  8  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write strobe, one-cycle pulse
mem_addr  output  ADDR_W  word address (byte address = mem_addr<<2)
mem_wdata  output  32  word to write
cpu_hold  output  1  1 = core held in reset
done  output  1  image loaded and checksum OK
err  output  1  frame error latched
err_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout
words_written  output  ADDR_W+1  words written in the current frame

Behaviour:
- Clock clk; reset is asynchronous, active-high.
- Reset values: state IDLE, s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, err_code=0, words_written=0. Internal byte counter, XOR accumulator and timeout counter all clear to 0.
- Byte accepted iff s_valid && s_ready. s_data is sampled only on acceptance. s_valid without s_ready has no effect.
- Frame format: SYNC, then N (word count, 1 byte), then 4*N data bytes, then a checksum byte.
  - Data bytes are little-endian per word: first byte goes to bits[7:0], fourth byte to bits[31:24].
  - Checksum = XOR of the 4*N data bytes only.
- IDLE:
  - s_ready=1.
  - Non-SYNC bytes are discarded.
  - SYNC -> LEN. On this transition: clear XOR accumulator, byte counter and words_written; clear err/err_code; set cpu_hold=1.
- LEN:
  - N==0 or N>2^ADDR_W -> ERROR, err_code=01.
  - Otherwise latch N -> DATA.
- DATA:
  - Each accepted byte is XORed into the accumulator and shifted into the word assembler.
  - On the 4th byte of a word, the next cycle produces mem_we=1 for exactly one cycle, with mem_addr=word index (0,1,...) and mem_wdata=assembled word. words_written increments in that same cycle.
  - mem_addr/mem_wdata hold their last values when mem_we=0.
  - s_ready stays 1 during the write pulse, so back-to-back bytes are accepted every cycle.
  - After byte 4*N -> CSUM.
- CSUM:
  - Byte == accumulator -> DONE.
  - Byte != accumulator -> ERROR, err_code=10.
- DONE:
  - done=1, cpu_hold=0 from the cycle after the checksum byte is accepted.
  - s_ready=0. Terminal until reset.
- ERROR:
  - err=1, cpu_hold=1, done=0, s_ready=1.
  - Non-SYNC bytes are discarded; SYNC restarts the frame (-> LEN as from IDLE). Previously written words are not erased.
- Timeout:
  - In LEN/DATA/CSUM the counter increments each cycle with no accepted byte and clears on every accepted byte.
  - When the count reaches TIMEOUT -> ERROR, err_code=11.
  - Acceptance has priority over timeout in the same cycle.
- Simultaneous events:
  - A pending mem_we pulse still issues even if the following cycle detects a timeout.
  - The final word's write pulse and the CSUM transition occur in the same cycle; the checksum cannot arrive before the last write completes.
- Reset mid-frame: immediate return to reset values. No further mem_we. Partially written memory is left as is.
- Counters: the word index wraps only through the length check, so an overflow write past 2^ADDR_W-1 is impossible.

Test Plan:
- Good 2-word load. Stream A5,02,63,86,94,00,13,00,00,00,62, s_valid continuous. Required:
  - mem_we pulses with addr0=0x00948663 and addr1=0x00000013.
  - words_written=2.
  - done=1, cpu_hold=0 one cycle after 0x62.
  - s_ready=0 afterwards.
- Bad checksum: same stream ending in 0x63 -> both words written, then err=1, err_code=10, cpu_hold=1, done=0.
- Bad length:
  - A5,00 -> err_code=01 with no mem_we.
  - A5,41 (65 > 64) -> err_code=01.
  - Leading junk 11,22 before A5 is ignored.
- Timeout: A5,01,63 then s_valid=0 for TIMEOUT cycles -> err_code=11 exactly TIMEOUT cycles after 0x63; no mem_we.
- Recovery and stalls:
  - After an error, a valid 1-word frame A5,01,13,00,00,00,13 -> err cleared on SYNC, addr0=0x00000013, done=1.
  - Random s_valid gaps shorter than TIMEOUT -> identical result.
- Reset mid-frame: assert reset after the 6th byte of the good frame -> next cycle all outputs at reset values. A subsequent full good frame loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader connects through the slave modport and the stream source/memory through master.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output s_data, s_valid,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a SYNC/len/data/checksum byte frame,
// writes little-endian words and holds the core in reset until a good image is in place.
module imem_loader #(
    parameter int          ADDR_W  = 6,
    parameter int          TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);

    localparam int LW   = ADDR_W + 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        acc_q, acc_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [LW-1:0]     words_written_q, words_written_d;

    logic s_ready;
    logic accept;
    logic in_frame;

    assign s_ready  = (state_q != S_DONE);
    assign accept   = bus.s_valid && s_ready;
    assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        byte_idx_d      = byte_idx_q;
        asm_d           = asm_q;
        acc_d           = acc_q;
        to_cnt_d        = to_cnt_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        cpu_hold_d      = cpu_hold_q;
        done_d          = done_q;
        err_d           = err_q;
        err_code_d      = err_code_q;
        words_written_d = words_written_q;

        if (in_frame) begin
            to_cnt_d = accept ? '0 : to_cnt_q + TO_W'(1);
        end

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (accept && bus.s_data == SYNC) begin
                    state_d         = S_LEN;
                    acc_d           = '0;
                    byte_idx_d      = '0;
                    to_cnt_d        = '0;
                    words_written_d = '0;
                    err_d           = 1'b0;
                    err_code_d      = 2'b00;
                    cpu_hold_d      = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (bus.s_data == 8'd0 || {24'd0, bus.s_data} > 32'(1 << ADDR_W)) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        len_d   = LW'(bus.s_data);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    acc_d      = acc_q ^ bus.s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    asm_d      = {bus.s_data, asm_q[23:8]};
                    // Fourth byte completes the word; the write pulse appears next cycle.
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d        = 1'b1;
                        mem_addr_d      = words_written_q[ADDR_W-1:0];
                        mem_wdata_d     = {bus.s_data, asm_q};
                        words_written_d = words_written_q + LW'(1);
                        if (words_written_q + LW'(1) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.s_data == acc_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            default: ;
        endcase

        // An accepted byte always wins over an expiring idle count.
        if (in_frame && !accept && to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b11;
            to_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            byte_idx_q      <= '0;
            asm_q           <= '0;
            acc_q           <= '0;
            to_cnt_q        <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            cpu_hold_q      <= 1'b1;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            err_code_q      <= 2'b00;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            byte_idx_q      <= byte_idx_d;
            asm_q           <= asm_d;
            acc_q           <= acc_d;
            to_cnt_q        <= to_cnt_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            cpu_hold_q      <= cpu_hold_d;
            done_q          <= done_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            words_written_q <= words_written_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign words_written  = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus
// and consumed by an independent write monitor; status outputs are checked after each frame.
module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_written;

    imem_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .SYNC    (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .words_written (words_written)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                                input logic [1:0] exp_code, input logic exp_hold,
                                input int exp_ww, input logic exp_ready);
        check_output({name, ".done"},          32'(done),          32'(exp_done));
        check_output({name, ".err"},           32'(err),           32'(exp_err));
        check_output({name, ".err_code"},      32'(err_code),      32'(exp_code));
        check_output({name, ".cpu_hold"},      32'(cpu_hold),      32'(exp_hold));
        check_output({name, ".words_written"}, 32'(words_written), 32'(exp_ww));
        check_output({name, ".s_ready"},       32'(bus.s_ready),   32'(exp_ready));
    endtask

    task automatic push_write(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Sends every byte of stim_q, optionally inserting random idle gaps shorter than TIMEOUT.
    task automatic apply_stimulus(input int max_gap);
        foreach (stim_q[i]) begin
            int  gap;
            int  n;
            logic accepted;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                bus.s_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            bus.s_data  = stim_q[i];
            bus.s_valid = 1'b1;
            n = 0;
            accepted = 1'b0;
            while (!accepted && n < 200) begin
                @(negedge clk);
                if (bus.s_ready === 1'b1) accepted = 1'b1;
                @(posedge clk);
                n++;
            end
            #1;
            if (!accepted) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_byte%0d: got no acceptance, expected s_ready within 200 cycles", i);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("write.addr", 32'(bus.mem_addr), 32'(e.addr));
                check_output("write.data", bus.mem_wdata, e.data);
            end
        end
    end

    initial begin
        int k;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #2;
        check_status("reset", 1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b1);
        check_output("reset.mem_we",    32'(bus.mem_we),   32'd0);
        check_output("reset.mem_addr",  32'(bus.mem_addr), 32'd0);
        check_output("reset.mem_wdata", bus.mem_wdata,     32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Good two-word frame preceded by junk
        push_write(0, 32'h0094_8663);
        push_write(1, 32'h0000_0013);
        stim_q = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'h63, 8'h86, 8'h94, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00};
        apply_stimulus(0);
        check_status("pre_csum", 1'b0, 1'b0, 2'b00, 1'b1, 2, 1'b1);
        stim_q = '{8'h62};
        apply_stimulus(0);
        check_status("good", 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0);
        check_output("good.sb_empty", 32'(exp_q.size()), 32'd0);
        bus.s_data  = 8'hA5;
        bus.s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check_status("done_hold", 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0);

        // Bad checksum
        do_reset();
        push_write(0, 32'h0094_8663);
        push_write(1, 32'h0000_0013);
        stim_q = '{8'hA5, 8'h02, 8'h63, 8'h86, 8'h94, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00, 8'h63};
        apply_stimulus(0);
        check_status("bad_csum", 1'b0, 1'b1, 2'b10, 1'b1, 2, 1'b1);
        check_output("bad_csum.sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero length from the error state
        stim_q = '{8'hA5};
        apply_stimulus(0);
        check_status("err_clear", 1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b1);
        stim_q = '{8'h00};
        apply_stimulus(0);
        check_status("len0", 1'b0, 1'b1, 2'b01, 1'b1, 0, 1'b1);

        // Length one past capacity
        stim_q = '{8'hA5, 8'h41};
        apply_stimulus(0);
        check_status("len65", 1'b0, 1'b1, 2'b01, 1'b1, 0, 1'b1);

        // Recovery with a one-word frame
        push_write(0, 32'h0000_0013);
        stim_q = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        apply_stimulus(0);
        check_status("recover", 1'b1, 1'b0, 2'b00, 1'b0, 1, 1'b0);
        check_output("recover.sb_empty", 32'(exp_q.size()), 32'd0);

        // Idle timeout mid-word
        do_reset();
        stim_q = '{8'hA5, 8'h01, 8'h63};
        apply_stimulus(0);
        k = 0;
        while (err !== 1'b1 && k < TIMEOUT + 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_output("timeout.cycles", 32'(k), 32'(TIMEOUT));
        check_status("timeout", 1'b0, 1'b1, 2'b11, 1'b1, 0, 1'b1);

        // Good frame with random stalls
        do_reset();
        push_write(0, 32'h0094_8663);
        push_write(1, 32'h0000_0013);
        stim_q = '{8'hA5, 8'h02, 8'h63, 8'h86, 8'h94, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00, 8'h62};
        apply_stimulus(5);
        check_status("stall", 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0);
        check_output("stall.sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset right after the byte that completes word 0
        do_reset();
        stim_q = '{8'hA5, 8'h02, 8'h63, 8'h86, 8'h94, 8'h00};
        apply_stimulus(0);
        reset = 1'b1;
        #2;
        check_status("midreset", 1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b1);
        check_output("midreset.mem_we",    32'(bus.mem_we),   32'd0);
        check_output("midreset.mem_addr",  32'(bus.mem_addr), 32'd0);
        check_output("midreset.mem_wdata", bus.mem_wdata,     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_write(0, 32'h0094_8663);
        push_write(1, 32'h0000_0013);
        stim_q = '{8'hA5, 8'h02, 8'h63, 8'h86, 8'h94, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00, 8'h62};
        apply_stimulus(0);
        check_status("after_reset", 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_output("final.sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
